// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : credit-limited instruction fetch with PC-tagged FIFO
// Rev 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  instr_op,
    output logic [2:0]  instr_funct3,
    output logic [6:0]  instr_funct7
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned PW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic [CW-1:0] drop_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          req_fire;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [31:0]   target_aligned;

    // Buffered words plus outstanding requests may never exceed the FIFO size,
    // so every response that survives dropping is guaranteed a free slot.
    assign credit_used    = {1'b0, count} + {1'b0, in_flight};
    assign imem_req_valid = (state == RUN) && (credit_used < DEPTH_C) && !redirect;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop       = (drop_cnt != '0);
    assign push           = imem_rsp_valid && !rsp_drop && !redirect;
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready && !redirect;
    assign target_aligned = redirect_target & ~32'd3;

    assign instr          = instr_valid ? word_mem[rd_ptr] : '0;
    assign instr_pc       = instr_valid ? pc_mem[rd_ptr]   : '0;
    assign instr_op       = instr[6:0];
    assign instr_funct3   = instr[14:12];
    assign instr_funct7   = instr[31:25];

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            count     <= '0;
            in_flight <= '0;
            drop_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                default: state <= RUN;
            endcase

            in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);

            if (redirect) begin
                fetch_pc <= target_aligned;
                rsp_pc   <= target_aligned;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                // Everything still outstanding after this cycle belongs to the old path.
                drop_cnt <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> ({1'b0, count} < DEPTH_C));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (in_flight != '0));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: in-order memory model with programmable
// latency, scoreboard of expected instruction stream and directed scenarios.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  instr_op;
    logic [2:0]  instr_funct3;
    logic [6:0]  instr_funct7;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_op(instr_op),
        .instr_funct3(instr_funct3), .instr_funct7(instr_funct7)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    logic [31:0] hs_log[$];
    logic [31:0] pop_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_fetch_pc = RESET_PC;
    logic [31:0] rsp_addr = '0;
    int          rsp_epoch = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F33;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    // Memory model: responds in order, at most one word per cycle.
    always begin
        @(posedge clk); #1;
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst_n) begin
            mq.delete();
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            rsp_addr       = mq[0].addr;
            rsp_epoch      = mq[0].epoch;
            void'(mq.pop_front());
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t  e;
        mreq_t m;
        if (!rst_n) begin
            exp_q.delete();
            exp_fetch_pc = RESET_PC;
            epoch++;
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h expected no instruction", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e.pc);
                    chk("sb_word", instr, e.word);
                    chk("sb_op", 32'(instr_op), 32'(e.word[6:0]));
                    chk("sb_funct3", 32'(instr_funct3), 32'(e.word[14:12]));
                    chk("sb_funct7", 32'(instr_funct7), 32'(e.word[31:25]));
                end
                pop_log.push_back(instr_pc);
            end
            if (imem_rsp_valid && !redirect && rsp_epoch == epoch) begin
                e.pc   = rsp_addr;
                e.word = mem_word(rsp_addr);
                exp_q.push_back(e);
            end
            if (redirect) begin
                chk("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
                epoch++;
                exp_fetch_pc = redirect_target & ~32'd3;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_fetch_pc);
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                hs_log.push_back(imem_req_addr);
                m.addr  = imem_req_addr;
                m.due   = cyc + lat;
                m.epoch = epoch;
                mq.push_back(m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int found;

        // Reset state
        repeat (3) tick();
        look();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_op", 32'(instr_op), 32'd0);
        tick();
        rst_n = 1'b1;
        look();
        chk("boot_no_req", 32'(imem_req_valid), 32'd0);

        // Backpressure: only DEPTH requests with decode stalled
        repeat (8) look();
        chk("bp_two_reqs", hs_log.size(), 32'd2);
        chk("bp_req_valid_low", 32'(imem_req_valid), 32'd0);
        chk("bp_instr_valid", 32'(instr_valid), 32'd1);
        chk("bp_head_pc", instr_pc, 32'h0000_0100);
        chk("bp_head_word", instr, mem_word(32'h0000_0100));
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (6) look();
        chk("bp_one_pop", pop_log.size(), 32'd1);
        chk("bp_three_reqs", hs_log.size(), 32'd3);
        chk("bp_req_valid_low2", 32'(imem_req_valid), 32'd0);

        // Free-running stream
        tick();
        instr_ready = 1'b1;
        repeat (12) tick();
        chk("stream_pc0", pop_log[0], 32'h0000_0100);
        chk("stream_pc1", pop_log[1], 32'h0000_0104);
        chk("stream_pc2", pop_log[2], 32'h0000_0108);

        // Redirect with two requests outstanding, no response in redirect cycle
        lat = 3;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            look();
            if (mq.size() == 2 && mq[0].due > cyc + 1) found = 1;
        end
        chk("t3_setup", 32'(found), 32'd1);
        idx = hs_log.size();
        tick();
        redirect = 1'b1;
        redirect_target = 32'h0000_2002;
        instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
        look();
        chk("t3_flush_empty", 32'(instr_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            look();
            if (instr_valid) found = 1;
        end
        chk("t3_valid_seen", 32'(found), 32'd1);
        chk("t3_first_pc", instr_pc, 32'h0000_2000);
        chk("t3_first_word", instr, mem_word(32'h0000_2000));
        chk("t3_first_req", hs_log[idx], 32'h0000_2000);

        // Redirect coinciding with a response
        tick();
        instr_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            look();
            if (mq.size() == 2 && mq[0].due == cyc + 1) found = 1;
        end
        chk("t4_setup", 32'(found), 32'd1);
        idx = hs_log.size();
        tick();
        redirect = 1'b1;
        redirect_target = 32'h0000_3001;
        instr_ready = 1'b0;
        tick();
        redirect = 1'b0;
        look();
        chk("t4_flush_empty", 32'(instr_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            look();
            if (instr_valid) found = 1;
        end
        chk("t4_valid_seen", 32'(found), 32'd1);
        chk("t4_first_pc", instr_pc, 32'h0000_3000);
        chk("t4_first_req", hs_log[idx], 32'h0000_3000);

        // PC wrap
        look();
        idx = hs_log.size();
        tick();
        lat = 1;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (14) look();
        chk("wrap_a0", hs_log[idx], 32'hFFFF_FFF8);
        chk("wrap_a1", hs_log[idx+1], 32'hFFFF_FFFC);
        chk("wrap_a2", hs_log[idx+2], 32'h0000_0000);

        // Asynchronous reset with FIFO full
        tick();
        instr_ready = 1'b0;
        repeat (8) look();
        chk("full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("full_instr_valid", 32'(instr_valid), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_instr_valid", 32'(instr_valid), 32'd0);
        idx = hs_log.size();
        repeat (2) tick();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        repeat (15) look();
        chk("restart_a0", hs_log[idx], RESET_PC);
        chk("restart_a1", hs_log[idx+1], RESET_PC + 32'd4);
        chk("total_pops_min", 32'(pop_log.size() >= 12), 32'd1);
        tick();
        instr_ready = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
